// File: rtl/vram_frame_writer.sv
// Frame writer for a ping-pong VRAM pair: fills the back bank, swaps on frame_sync.
// Optional VRAM_WR_CLEAR_EN adds clr_req/CLR_COLOR to fill the back bank with a colour.
module vram_frame_writer #(
    parameter int H_PIX  = 200,
    parameter int V_PIX  = 150,
    parameter int ADDR_W = 15
`ifdef VRAM_WR_CLEAR_EN
    ,
    parameter logic [11:0] CLR_COLOR = 12'h000
`endif
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [11:0]       s_data,
    input  logic              s_sof,
    input  logic              frame_sync,
`ifdef VRAM_WR_CLEAR_EN
    input  logic              clr_req,
`endif
    output logic              wea,
    output logic [ADDR_W-1:0] waddr,
    output logic [11:0]       wdata,
    output logic              wbank,
    output logic              rbank,
    output logic              frame_done,
    output logic              err_sof
);

    localparam int NPIX = H_PIX * V_PIX;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_SWAP = 2'd2
`ifdef VRAM_WR_CLEAR_EN
        ,
        CLEAR     = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [11:0]         wdata_q, wdata_d;
    logic                wbank_q, wbank_d;
    logic                frame_done_q, frame_done_d;
    logic                err_sof_q, err_sof_d;
    logic                ready;
    logic                acc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wea_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wbank_d      = wbank_q;
        frame_done_d = 1'b0;
        err_sof_d    = 1'b0;
        ready        = 1'b0;

        // A pending clear blocks acceptance so it wins over a same-cycle sof beat
        if (state_q == IDLE) begin
`ifdef VRAM_WR_CLEAR_EN
            ready = ~clr_req;
`else
            ready = 1'b1;
`endif
        end else if (state_q == WRITE) begin
            ready = 1'b1;
        end
        acc = s_valid & ready;

        unique case (state_q)
            IDLE: begin
`ifdef VRAM_WR_CLEAR_EN
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else
`endif
                if (acc && s_sof) begin
                    wea_d   = 1'b1;
                    waddr_d = '0;
                    wdata_d = s_data;
                    cnt_d   = ONE;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (acc) begin
                    wea_d   = 1'b1;
                    wdata_d = s_data;
                    if (s_sof) begin
                        err_sof_d = 1'b1;
                        waddr_d   = '0;
                        cnt_d     = ONE;
                    end else begin
                        waddr_d = cnt_q;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = WAIT_SWAP;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_sync) begin
                    wbank_d      = ~wbank_q;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
`ifdef VRAM_WR_CLEAR_EN
            CLEAR: begin
                wea_d   = 1'b1;
                waddr_d = cnt_q;
                wdata_d = CLR_COLOR;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wea_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wbank_q      <= 1'b1;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wea_q        <= wea_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wbank_q      <= wbank_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign s_ready    = ready & rstn;
    assign wea        = wea_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign wbank      = wbank_q;
    assign rbank      = ~wbank_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

endmodule
